cla_pg_stage: RTL and testbench



---
 rtl/cla_pkg.sv | 17 +
 rtl/pg_skid_fifo2.sv | 106 ++++++++++
 rtl/cla_pg_stage.sv | 58 +++++
 tb/tb_cla_pg_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and payload type for the carry-look-ahead adder front end.
package cla_pkg;

    localparam int unsigned CLA_WIDTH = 32;
    localparam int unsigned GROUP_W   = 4;
    localparam int unsigned DEPTH_W   = 2;

    // 'generate' is a reserved word, so the generate vector is the 'gen' field.
    typedef struct packed {
        logic [CLA_WIDTH-1:0] propagate;
        logic [CLA_WIDTH-1:0] gen;
        logic                 cin;
    } pg_entry_t;

    localparam int unsigned ENTRY_W = $bits(pg_entry_t);

endpackage

// File: rtl/pg_skid_fifo2.sv
// Generic 2-entry valid/ready FIFO; head is a plain register and both ready and
// valid come from flops, so there is no combinational path across the stage.
module pg_skid_fifo2 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic              valid_q;
    logic              ready_q;
    logic              push_c;
    logic              pop_c;
    logic              load_head_c;
    logic              shift_head_c;
    logic              load_tail_c;

    assign push_c = in_valid_i && ready_q;
    assign pop_c  = valid_q && out_ready_i;

    // Occupancy transitions and register write enables.
    always_comb begin
        state_d      = state_q;
        load_head_c  = 1'b0;
        shift_head_c = 1'b0;
        load_tail_c  = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (push_c) begin
                    state_d     = ST_ONE;
                    load_head_c = 1'b1;
                end
            end
            ST_ONE: begin
                if (push_c && pop_c) begin
                    load_head_c = 1'b1;
                end else if (push_c) begin
                    state_d     = ST_FULL;
                    load_tail_c = 1'b1;
                end else if (pop_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop_c) begin
                    state_d      = ST_ONE;
                    shift_head_c = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State plus flag flops precomputed from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != ST_EMPTY);
            ready_q <= (state_d != ST_FULL);
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head_c) begin
                head_q <= in_data_i;
            end else if (shift_head_c) begin
                head_q <= tail_q;
            end
            if (load_tail_c) begin
                tail_q <= in_data_i;
            end
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = head_q;
    assign occupancy_o = 2'(state_q);

endmodule

// File: rtl/cla_pg_stage.sv
// Operand stage feeding the 4-bit CLA groups: per-bit propagate/generate,
// buffered in a 2-entry FIFO so the group logic sees registered P/G vectors.
module cla_pg_stage
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH   = CLA_WIDTH,
    parameter int unsigned DEPTH_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               cin_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   propagate_o,
    output logic [WIDTH-1:0]   generate_o,
    output logic               cin_o,
    output logic [DEPTH_W-1:0] occupancy_o
);

    // Payload type is sized by the package, so WIDTH must agree with it.
    if ((WIDTH % GROUP_W) != 0 || WIDTH != CLA_WIDTH || DEPTH_W != 2) begin : g_param_check
        $error("cla_pg_stage: WIDTH must be a multiple of GROUP_W and equal CLA_WIDTH; DEPTH_W must be 2");
    end

    pg_entry_t in_entry_c;
    pg_entry_t head;

    assign in_entry_c.propagate = a_i ^ b_i;
    assign in_entry_c.gen       = a_i & b_i;
    assign in_entry_c.cin       = cin_i;

    pg_skid_fifo2 #(
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_entry_c),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (head),
        .occupancy_o (occupancy_o)
    );

    assign propagate_o = head.propagate;
    assign generate_o  = head.gen;
    assign cin_o       = head.cin;

    // A bit can never both propagate and generate.
    a_pg_disjoint: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o |-> ((propagate_o & generate_o) == '0));

endmodule

// File: tb/tb_cla_pg_stage.sv
// Self-checking bench for cla_pg_stage: directed scenarios plus randomized
// traffic compared against a queue-based reference of the FIFO behaviour.
module tb_cla_pg_stage;
    import cla_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cin_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] propagate_o;
    logic [31:0] generate_o;
    logic        cin_o;
    logic [1:0]  occupancy_o;

    int n_checks;
    int n_fail;

    pg_entry_t model_q[$];
    logic      hold;

    cla_pg_stage dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .propagate_o (propagate_o),
        .generate_o  (generate_o),
        .cin_o       (cin_o),
        .occupancy_o (occupancy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Upstream protocol: a stalled pair must stay put until accepted.
    logic        prev_stall;
    logic [31:0] prev_a;
    logic [31:0] prev_b;
    logic        prev_c;
    always @(posedge clk_i) begin
        if (rst_ni && prev_stall && in_valid_i)
            assert (a_i == prev_a && b_i == prev_b && cin_i == prev_c);
        prev_stall <= rst_ni && in_valid_i && !in_ready_o;
        prev_a     <= a_i;
        prev_b     <= b_i;
        prev_c     <= cin_i;
    end

    // Reference P/G from the bit-level definitions.
    function automatic pg_entry_t ref_pg(input logic [31:0] a, input logic [31:0] b, input logic c);
        pg_entry_t e;
        for (int k = 0; k < 32; k++) begin
            e.propagate[k] = (a[k] != b[k]);
            e.gen[k]       = a[k] && b[k];
        end
        e.cin = c;
        return e;
    endfunction

    // Drive one cycle and advance the reference queue; returns at posedge+1.
    task automatic cycle(input logic vld, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic ordy);
        logic push;
        logic pop;
        in_valid_i = vld;
        if (!(hold && vld)) begin
            a_i   = a;
            b_i   = b;
            cin_i = c;
        end
        out_ready_i = ordy;
        push = vld && (model_q.size() != 2);
        pop  = (model_q.size() != 0) && ordy;
        @(posedge clk_i);
        #1;
        if (pop) void'(model_q.pop_front());
        if (push) model_q.push_back(ref_pg(a_i, b_i, cin_i));
        hold = vld && !push;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        in_valid_i = 1'b0; out_ready_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
        hold = 1'b0;
        model_q.delete();
        @(posedge clk_i); #1;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", in_ready_o); end
        n_checks++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
        n_checks++;
        if ({propagate_o, generate_o, cin_o} !== 65'd0) begin
            n_fail++; $display("FAIL reset_data: got P=%h G=%h c=%b want zeros", propagate_o, generate_o, cin_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_single_pair();
        cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", out_valid_o); end
        n_checks++; if (propagate_o !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL single_p: got %h want fffffffe", propagate_o); end
        n_checks++; if (generate_o !== 32'h0000_0001) begin n_fail++; $display("FAIL single_g: got %h want 00000001", generate_o); end
        n_checks++; if (cin_o !== 1'b0) begin n_fail++; $display("FAIL single_cin: got %b want 0", cin_o); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL single_occ_after: got %0d want 0", occupancy_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %0b want 0", out_valid_o); end
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0);
        n_checks++; if (occupancy_o !== 2'd1) begin n_fail++; $display("FAIL bp_occ1: got %0d want 1", occupancy_o); end
        cycle(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %0b want 0", in_ready_o); end
        n_checks++; if (occupancy_o !== 2'd2) begin n_fail++; $display("FAIL bp_occ2: got %0d want 2", occupancy_o); end
        cycle(1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0);
        n_checks++; if (occupancy_o !== 2'd2) begin n_fail++; $display("FAIL bp_third_rejected: got occ %0d want 2", occupancy_o); end
        n_checks++; if (propagate_o !== 32'h1D3B_5977) begin n_fail++; $display("FAIL bp_head_p: got %h want 1d3b5977", propagate_o); end
        n_checks++; if (generate_o !== 32'h0204_0608) begin n_fail++; $display("FAIL bp_head_g: got %h want 02040608", generate_o); end
        n_checks++; if (cin_o !== 1'b0) begin n_fail++; $display("FAIL bp_head_cin: got %b want 0", cin_o); end
    endtask

    task automatic test_drain();
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++; if (occupancy_o !== 2'd1) begin n_fail++; $display("FAIL drain_occ1: got %0d want 1", occupancy_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %0b want 1", in_ready_o); end
        n_checks++; if (propagate_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL drain_p: got %h want ffffffff", propagate_o); end
        n_checks++; if (generate_o !== 32'h0000_0000) begin n_fail++; $display("FAIL drain_g: got %h want 00000000", generate_o); end
        n_checks++; if (cin_o !== 1'b1) begin n_fail++; $display("FAIL drain_cin: got %b want 1", cin_o); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL drain_occ0: got %0d want 0", occupancy_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %0b want 0", out_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sa;
        logic [31:0] sb;
        logic        sc;
        pg_entry_t   exp_e;
        for (int i = 0; i < 16; i++) begin
            sa = $urandom; sb = $urandom; sc = 1'($urandom_range(0, 1));
            exp_e = ref_pg(sa, sb, sc);
            cycle(1'b1, sa, sb, sc, 1'b1);
            n_checks++; if (occupancy_o !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy_o); end
            n_checks++;
            if (out_valid_o !== 1'b1 || {propagate_o, generate_o, cin_o} !== {exp_e.propagate, exp_e.gen, exp_e.cin}) begin
                n_fail++;
                $display("FAIL stream_data[%0d]: got v=%b P=%h G=%h c=%b want P=%h G=%h c=%b", i, out_valid_o,
                         propagate_o, generate_o, cin_o, exp_e.propagate, exp_e.gen, exp_e.cin);
            end
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL stream_drain: got occ %0d want 0", occupancy_o); end
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            n_checks++;
            if (occupancy_o !== 2'(model_q.size()) || out_valid_o !== (model_q.size() != 0)
                || in_ready_o !== (model_q.size() != 2)) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: got occ=%0d v=%b r=%b want occ=%0d", i, occupancy_o,
                         out_valid_o, in_ready_o, model_q.size());
            end
            if (model_q.size() != 0) begin
                n_checks++;
                if ({propagate_o, generate_o, cin_o} !== {model_q[0].propagate, model_q[0].gen, model_q[0].cin}) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got P=%h G=%h c=%b want P=%h G=%h c=%b", i, propagate_o,
                             generate_o, cin_o, model_q[0].propagate, model_q[0].gen, model_q[0].cin);
                end
                n_checks++;
                if ((propagate_o & generate_o) !== 32'd0) begin
                    n_fail++; $display("FAIL rand_pg_disjoint[%0d]: got P&G=%h want 0", i, propagate_o & generate_o);
                end
            end
        end
        for (int i = 0; i < 10 && model_q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++;
        if (model_q.size() != 0 || occupancy_o !== 2'd0) begin
            n_fail++; $display("FAIL rand_drain: got occ %0d want 0 within 10 cycles", occupancy_o);
        end
    endtask

    task automatic test_async_reset();
        pg_entry_t exp_e;
        cycle(1'b1, 32'h1111_2222, 32'h3333_4444, 1'b1, 1'b0);
        cycle(1'b1, 32'h5555_6666, 32'h7777_8888, 1'b0, 1'b0);
        n_checks++; if (occupancy_o !== 2'd2) begin n_fail++; $display("FAIL arst_prefill: got occ %0d want 2", occupancy_o); end
        #3;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b want 0", out_valid_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %0b want 1", in_ready_o); end
        n_checks++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL arst_occ: got %0d want 0", occupancy_o); end
        n_checks++;
        if ({propagate_o, generate_o, cin_o} !== 65'd0) begin
            n_fail++; $display("FAIL arst_data: got P=%h G=%h c=%b want zeros", propagate_o, generate_o, cin_o);
        end
        model_q.delete();
        hold = 1'b0;
        in_valid_i = 1'b1; a_i = 32'hFFFF_0000; b_i = 32'h00FF_FF00; cin_i = 1'b1;
        @(posedge clk_i); #1;
        n_checks++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL arst_ignore_in: got occ %0d want 0", occupancy_o); end
        in_valid_i = 1'b0;
        #1;
        rst_ni = 1'b1;
        exp_e = ref_pg(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b1);
        cycle(1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++; if (occupancy_o !== 2'd1) begin n_fail++; $display("FAIL arst_post_occ: got %0d want 1", occupancy_o); end
        n_checks++;
        if ({propagate_o, generate_o, cin_o} !== {exp_e.propagate, exp_e.gen, exp_e.cin}) begin
            n_fail++;
            $display("FAIL arst_post_head: got P=%h G=%h c=%b want P=%h G=%h c=%b", propagate_o, generate_o,
                     cin_o, exp_e.propagate, exp_e.gen, exp_e.cin);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_no_stale: got v=%b want 0", out_valid_o); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_pair();
        test_backpressure();
        test_drain();
        test_back_to_back();
        test_random_traffic();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
